memory_arbiter: RTL and testbench

//  Two-port request/acknowledge arbiter in front of the single-port memory_unit.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/rr_select2.sv | 24 ++
 rtl/memory_arbiter.sv | 134 +++++++++++++
 tb/tb_memory_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory types, flags, sizes and arbiter state encoding
package mem_pkg;

    localparam int MEMSIZE = 16;
    localparam int REGSIZE = 8;

    typedef logic [REGSIZE-1:0] DEFAULT_TYPE;

    typedef enum logic [3:0] {
        MEMORY_STAY  = 4'd0,
        MEMORY_READ  = 4'd1,
        MEMORY_WRITE = 4'd2
    } MEMORY_FLAG;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_DONE
    } arb_state_t;

endpackage

// File: rtl/rr_select2.sv
// rtl/rr_select2.sv - combinational two-way round-robin picker
// Ports:
//   req[1:0]  in   per-port request
//   prio      in   port favoured when both request
//   gnt_valid out  at least one request present
//   gnt_sel   out  index of the winning port
module rr_select2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_valid,
    output logic       gnt_sel
);

    always_comb begin
        gnt_valid = |req;
        gnt_sel   = 1'b0;
        case (req)
            2'b10:   gnt_sel = 1'b1;
            2'b11:   gnt_sel = prio;
            default: gnt_sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-port round-robin arbiter in front of the single-port memory_unit
// Ports:
//   CLOCK, RESET            clock; synchronous active-low reset
//   req/we[1:0]             per-port request and write enable (port 0 fetch, port 1 data)
//   addr0/1, wdata0/1       per-port word address and write data
//   ack/err[1:0]            one-cycle completion pulse and out-of-range flag of the winner
//   rdata                   read result, valid with ack
//   busy                    high while an access is in flight (ACCESS, DONE)
//   mem_flag/addr/wdata     command to memory_unit
//   mem_rdata               combinational read data from memory_unit
module memory_arbiter #(
    parameter int MEMSIZE = mem_pkg::MEMSIZE,
    parameter int REGSIZE = mem_pkg::REGSIZE
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [1:0]         req,
    input  logic [1:0]         we,
    input  logic [REGSIZE-1:0] addr0,
    input  logic [REGSIZE-1:0] addr1,
    input  logic [REGSIZE-1:0] wdata0,
    input  logic [REGSIZE-1:0] wdata1,
    output logic [1:0]         ack,
    output logic [1:0]         err,
    output logic [REGSIZE-1:0] rdata,
    output logic               busy,
    output logic [3:0]         mem_flag,
    output logic [REGSIZE-1:0] mem_addr,
    output logic [REGSIZE-1:0] mem_wdata,
    input  logic [REGSIZE-1:0] mem_rdata
);

    import mem_pkg::*;

    arb_state_t         state, state_d;
    logic               prio;
    logic               gnt_valid, gnt_sel;
    logic               sel_q, we_q;
    logic [REGSIZE-1:0] addr_q, wdata_q;
    logic               in_range;

    rr_select2 u_rr_select2 (
        .req       (req),
        .prio      (prio),
        .gnt_valid (gnt_valid),
        .gnt_sel   (gnt_sel)
    );

    // Compared at address width so large addresses never alias into range.
    assign in_range = (addr_q < REGSIZE'(MEMSIZE));

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        busy      = 1'b0;
        mem_flag  = MEMORY_STAY;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                busy      = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (in_range) begin
                    mem_flag = we_q ? MEMORY_WRITE : MEMORY_READ;
                end
                state_d = ARB_DONE;
            end
            ARB_DONE: begin
                busy    = 1'b1;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        // A reset landing mid-access must not let the write reach memory.
        if (!RESET) begin
            mem_flag = MEMORY_STAY;
        end
    end

    // ack/err are loaded at the ACCESS->DONE edge so they are high exactly in DONE.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            prio    <= 1'b0;
            ack     <= '0;
            err     <= '0;
            rdata   <= '0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    ack <= '0;
                    err <= '0;
                    if (gnt_valid) begin
                        sel_q   <= gnt_sel;
                        we_q    <= we[gnt_sel];
                        addr_q  <= gnt_sel ? addr1 : addr0;
                        wdata_q <= gnt_sel ? wdata1 : wdata0;
                    end
                end
                ARB_ACCESS: begin
                    ack   <= {sel_q, ~sel_q};
                    err   <= in_range ? 2'b00 : {sel_q, ~sel_q};
                    rdata <= (in_range && !we_q) ? mem_rdata : '0;
                end
                ARB_DONE: begin
                    ack  <= '0;
                    err  <= '0;
                    prio <= ~sel_q;
                end
                default: begin
                    ack <= '0;
                    err <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter
module tb_memory_arbiter;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [1:0] req, we;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic [1:0] ack, err;
    logic [7:0] rdata;
    logic       busy;
    logic [3:0] mem_flag;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    localparam logic [3:0] F_STAY  = 4'd0;
    localparam logic [3:0] F_READ  = 4'd1;
    localparam logic [3:0] F_WRITE = 4'd2;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:15];

    always #5 CLOCK = ~CLOCK;

    assign mem_rdata = (mem_addr < 8'd16) ? mem[mem_addr[3:0]] : 8'h00;

    always @(posedge CLOCK) begin
        if (mem_flag == F_WRITE && mem_addr < 8'd16) begin
            mem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    memory_arbiter dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .mem_flag  (mem_flag),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RESET = 1'b0; req = 2'b00; we = 2'b00;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);

        // 1: reset
        step(); step();
        RESET = 1'b1;
        step();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_flag", 32'(mem_flag), 32'(F_STAY));
        chk("rst_maddr", 32'(mem_addr), 32'h0);
        chk("rst_prio", 32'(dut.prio), 32'h0);

        // 2: port1 write addr 5, then port0 read addr 5
        req = 2'b10; we = 2'b10; addr1 = 8'd5; wdata1 = 8'hA5;
        step();
        chk("wr_flag", 32'(mem_flag), 32'(F_WRITE));
        chk("wr_maddr", 32'(mem_addr), 32'd5);
        chk("wr_mwdata", 32'(mem_wdata), 32'hA5);
        chk("wr_busy", 32'(busy), 32'h1);
        chk("wr_noack", 32'(ack), 32'h0);
        step();
        chk("wr_ack", 32'(ack), 32'h2);
        chk("wr_err", 32'(err), 32'h0);
        chk("wr_rdata", 32'(rdata), 32'h0);
        chk("wr_mem", 32'(mem[5]), 32'hA5);
        chk("wr_done_flag", 32'(mem_flag), 32'(F_STAY));
        req = 2'b00; we = 2'b00;
        step();
        chk("wr_idle_ack", 32'(ack), 32'h0);
        chk("wr_idle_busy", 32'(busy), 32'h0);
        req = 2'b01; addr0 = 8'd5;
        step();
        chk("rd_flag", 32'(mem_flag), 32'(F_READ));
        step();
        chk("rd_ack", 32'(ack), 32'h1);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        chk("rd_err", 32'(err), 32'h0);
        req = 2'b00;
        step();

        // 3: both ports request continuously, starting from prio 0
        RESET = 1'b0;
        step(); step();
        RESET = 1'b1;
        req = 2'b11; we = 2'b00; addr0 = 8'd1; addr1 = 8'd2;
        for (int g = 0; g < 4; g++) begin
            step();
            chk("rr_access_ack", 32'(ack), 32'h0);
            chk("rr_access_busy", 32'(busy), 32'h1);
            step();
            chk("rr_ack", 32'(ack), (g % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_rdata", 32'(rdata), (g % 2 == 0) ? 32'h11 : 32'h12);
            if (g == 3) req = 2'b00;
            step();
            chk("rr_idle_ack", 32'(ack), 32'h0);
            chk("rr_idle_busy", 32'(busy), 32'h0);
        end

        // 4: port0 read at MEMSIZE is rejected
        req = 2'b01; we = 2'b00; addr0 = 8'd16;
        step();
        chk("oor_flag_acc", 32'(mem_flag), 32'(F_STAY));
        chk("oor_busy", 32'(busy), 32'h1);
        step();
        chk("oor_ack", 32'(ack), 32'h1);
        chk("oor_err", 32'(err), 32'h1);
        chk("oor_rdata", 32'(rdata), 32'h0);
        chk("oor_flag_done", 32'(mem_flag), 32'(F_STAY));
        chk("oor_mem0", 32'(mem[0]), 32'h10);
        req = 2'b00;
        step();

        // 5: reset pulsed during the ACCESS cycle of a write
        req = 2'b10; we = 2'b10; addr1 = 8'd3; wdata1 = 8'h3C;
        step();
        RESET = 1'b0;
        #1;
        chk("rstacc_flag", 32'(mem_flag), 32'(F_STAY));
        step();
        RESET = 1'b1; req = 2'b00; we = 2'b00;
        chk("rstacc_ack", 32'(ack), 32'h0);
        chk("rstacc_busy", 32'(busy), 32'h0);
        chk("rstacc_mem3", 32'(mem[3]), 32'h13);
        step();
        chk("rstacc_ack2", 32'(ack), 32'h0);
        chk("rstacc_busy2", 32'(busy), 32'h0);

        // 6: port0 drops req after the grant
        req = 2'b01; addr0 = 8'd7;
        step();
        req = 2'b00;
        chk("drop_busy", 32'(busy), 32'h1);
        step();
        chk("drop_ack", 32'(ack), 32'h1);
        chk("drop_rdata", 32'(rdata), 32'h17);
        step();
        chk("drop_idle_ack", 32'(ack), 32'h0);
        step();
        chk("drop_no_second", 32'(busy), 32'h0);
        chk("drop_no_ack", 32'(ack), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
